// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter for the ALU, load and mul/div producers.
// Grants one requester per cycle and drives a registered write (index, data, strobe).
module wb_port_arbiter #(
    parameter int NREQ         = 3,
    parameter int MEM_PRIORITY = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [4:0]        req_index0,
    input  logic [4:0]        req_index1,
    input  logic [4:0]        req_index2,
    input  logic [31:0]       req_data0,
    input  logic [31:0]       req_data1,
    input  logic [31:0]       req_data2,
    output logic [NREQ-1:0]   req_ready,
    output logic              wb_write,
    output logic [4:0]        wb_index,
    output logic [31:0]       wb_data,
    output logic [CNT_W-1:0]  stall_count
);

    logic [1:0]        r_rr_ptr;
    logic              r_wb_write;
    logic [4:0]        r_wb_index;
    logic [31:0]       r_wb_data;
    logic [CNT_W-1:0]  r_stall_count;

    logic [NREQ-1:0]   w_grant;
    logic [1:0]        w_sel;
    logic [1:0]        w_next_ptr;
    logic [4:0]        w_index;
    logic [31:0]       w_data;
    logic              w_xfer;
    logic              w_stall;

    // Grant selection: load priority override, otherwise round-robin search from r_rr_ptr.
    always_comb begin
        w_grant = 3'b000;
        if (rst || !enable || (req_valid == 3'b000)) begin
            w_grant = 3'b000;
        end else if ((MEM_PRIORITY != 0) && req_valid[1]) begin
            w_grant = 3'b010;
        end else begin
            case (r_rr_ptr)
                2'd1: begin
                    if (req_valid[1])      w_grant = 3'b010;
                    else if (req_valid[2]) w_grant = 3'b100;
                    else if (req_valid[0]) w_grant = 3'b001;
                    else                   w_grant = 3'b000;
                end
                2'd2: begin
                    if (req_valid[2])      w_grant = 3'b100;
                    else if (req_valid[0]) w_grant = 3'b001;
                    else if (req_valid[1]) w_grant = 3'b010;
                    else                   w_grant = 3'b000;
                end
                default: begin
                    if (req_valid[0])      w_grant = 3'b001;
                    else if (req_valid[1]) w_grant = 3'b010;
                    else if (req_valid[2]) w_grant = 3'b100;
                    else                   w_grant = 3'b000;
                end
            endcase
        end
    end

    // Encode the grant, pick the winner's payload and the pointer that follows it.
    always_comb begin
        w_sel      = 2'd0;
        w_next_ptr = r_rr_ptr;
        w_index    = req_index0;
        w_data     = req_data0;
        case (w_grant)
            3'b001:  w_sel = 2'd0;
            3'b010:  w_sel = 2'd1;
            3'b100:  w_sel = 2'd2;
            default: w_sel = 2'd0;
        endcase
        case (w_sel)
            2'd1: begin
                w_index    = req_index1;
                w_data     = req_data1;
                w_next_ptr = 2'd2;
            end
            2'd2: begin
                w_index    = req_index2;
                w_data     = req_data2;
                w_next_ptr = 2'd0;
            end
            default: begin
                w_index    = req_index0;
                w_data     = req_data0;
                w_next_ptr = 2'd1;
            end
        endcase
    end

    assign w_xfer  = (w_grant != 3'b000);
    // A stall is any valid requester left waiting while the pipeline is advancing.
    assign w_stall = enable && ((req_valid & ~w_grant) != 3'b000);

    // Registered write port, round-robin pointer and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr      <= 2'd0;
            r_wb_write    <= 1'b0;
            r_wb_index    <= 5'd0;
            r_wb_data     <= 32'd0;
            r_stall_count <= {CNT_W{1'b0}};
        end else begin
            if (w_xfer) begin
                r_rr_ptr   <= w_next_ptr;
                // Writes to x0 are consumed but never strobed into the register file.
                r_wb_write <= (w_index != 5'd0);
                r_wb_index <= w_index;
                r_wb_data  <= w_data;
            end else begin
                r_rr_ptr   <= r_rr_ptr;
                r_wb_write <= 1'b0;
                r_wb_index <= r_wb_index;
                r_wb_data  <= r_wb_data;
            end
            if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
                r_stall_count <= r_stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_stall_count <= r_stall_count;
            end
        end
    end

    assign req_ready   = w_grant;
    assign wb_write    = r_wb_write;
    assign wb_index    = r_wb_index;
    assign wb_data     = r_wb_data;
    assign stall_count = r_stall_count;

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between three result producers: 0 = execute/ALU, 1 = memory/load, 2 = multi-cycle mul/div unit.
- Each producer presents a valid/ready request. The block grants at most one producer per cycle and drives a registered write onto the port (index, data, write strobe).
- Sits between the execute/memory/MDU stages and the register file, taking over the write-port driving role from the writeback stage.
- Also keeps a saturating count of contention stalls for performance monitoring.

Parameters:
- NREQ, 3, number of requesters; fixed at 3 for this revision; values other than 3 are unsupported.
- MEM_PRIORITY, 1, when 1 requester 1 (load) always wins if valid; when 0 pure round-robin across all three.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- enable  input  1  global advance; when 0 no grants are issued.
- req_valid  input  3  bit i = requester i has a result to write.
- req_index0 / req_index1 / req_index2  input  5 each  destination register per requester.
- req_data0 / req_data1 / req_data2  input  32 each  result data per requester.
- req_ready  output  3  combinational one-hot (or zero) grant; bit i = requester i's result is consumed this cycle.
- wb_write  output  1  registered register-file write strobe.
- wb_index  output  5  registered write index.
- wb_data  output  32  registered write data.
- stall_count  output  CNT_W  saturating count of cycles with at least one valid requester not granted.

Behaviour:
- Reset (rst=1 at a clock edge):
  - wb_write=0, wb_index=0, wb_data=0, stall_count=0, rr_ptr=0.
  - req_ready is forced to 0 in any cycle in which rst=1.
  - Reset mid-operation discards the in-flight output write; requesters must re-present.
- Grant, combinational from req_valid, enable, rr_ptr:
  - enable=0 or req_valid=0: req_ready=0.
  - MEM_PRIORITY=1 and req_valid[1]=1: grant requester 1.
  - Otherwise: search from rr_ptr upward modulo 3; first valid requester wins.
  - req_ready is always one-hot or zero.
- Handshake:
  - A transfer occurs when req_valid[i] and req_ready[i] are both 1.
  - A requester holds its valid, index and data stable until ready.
  - req_ready never asserts without the matching valid.
- Output, latency 1 cycle:
  - On a transfer, the next edge sets wb_index and wb_data to the granted requester's values.
  - wb_write=1 on that edge unless the granted index is 0; x0 writes are consumed (ready=1) but wb_write=0, while wb_index and wb_data still update.
  - No transfer: wb_write=0 on the next edge; wb_index and wb_data hold.
- Round-robin pointer rr_ptr, 2 bits, range 0..2:
  - After a grant to requester i, rr_ptr=(i+1) mod 3. This also applies to priority grants of requester 1.
  - No grant: rr_ptr holds.
  - rr_ptr never takes the value 3.
- Stall counter:
  - Increments by 1 on each edge where enable=1 and some req_valid bit is 1 but not granted.
  - Saturates at all-ones.
  - enable=0 cycles are not counted.
- Simultaneous requests to the same index: each is written in separate cycles in grant order, so the later grant's value remains in the register. Ordering is the producers' responsibility.

Test Plan:
- Reset: assert rst with req_valid=3'b111 -> req_ready=0; wb_write=0, wb_index=0, wb_data=0, stall_count=0 after the edge.
- Single ALU write: req_valid=3'b001, index0=5, data0=0x12345678 -> req_ready=3'b001 same cycle; next cycle wb_write=1, wb_index=5, wb_data=0x12345678; following cycle wb_write=0.
- Load priority (MEM_PRIORITY=1): req_valid=3'b111 held 3 cycles -> grants 1, 1, 1; requesters 0 and 2 stall; stall_count=3.
- Round-robin (MEM_PRIORITY=0): req_valid=3'b111, each requester dropping its valid after its grant -> grants 0, then 1, then 2 on consecutive cycles; stall_count=2; rr_ptr returns to 0.
- x0 squash: requester 2 valid with index 0, data 0xDEADBEEF -> req_ready[2]=1; next cycle wb_write=0.
- Enable gating and saturation: enable=0 with req_valid=3'b001 -> ready=0, count unchanged. With CNT_W=2, 5 contended cycles -> stall_count stays at 3.
